// File: rtl/rv_lsu_axil_if.sv
// Bundle of the execute-stage request/response port and the AXI4-Lite
// data-side master channels of the rv_lsu_axil load/store unit.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer
// happens on a rising clk edge where both valid and ready are 1; once a
// source raises valid it holds valid and its payload stable until that
// transfer. rsp_valid is the exception: a one-cycle pulse, no ready.
interface rv_lsu_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // execute-stage request / response
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_we;
  logic [1:0]          req_size;
  logic                req_unsigned;
  logic [DATA_W-1:0]   req_wdata;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic [3:0]          rsp_cause;

  // AXI4-Lite read channels
  logic [ADDR_W-1:0]   m_araddr;
  logic                m_arvalid;
  logic                m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rvalid;
  logic                m_rready;

  // AXI4-Lite write channels
  logic [ADDR_W-1:0]   m_awaddr;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;

  // LSU side: serves the execute stage, masters the bus
  modport master (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_cause,
    output m_araddr, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready,
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready
  );

  // environment side: execute stage plus AXI4-Lite slave
  modport slave (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_cause,
    input  m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready,
    input  m_awaddr, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready
  );
endinterface

// File: rtl/rv_lsu_axil.sv
// rv_lsu_axil: single-outstanding load/store unit with an AXI4-Lite master.
// Checks alignment, steers byte lanes, builds write strobes and sign/zero
// extends load data for a 32- or 64-bit bus. Returns one response pulse per
// request carrying data or a RISC-V exception cause.
//
// Optional build macro LSU_BUS_TIMEOUT_EN: adds a bus watchdog that aborts a
// transaction after TIMEOUT_CYCLES busy cycles (cause 5 load / 7 store) and
// keeps m_rready/m_bready high in IDLE so stray late beats are swallowed.
module rv_lsu_axil #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst,
  rv_lsu_axil_if.master  bus,
  output logic [2:0]     dbg_state_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_RESP    = 3'd5
  } state_t;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam logic IDLE_RDY = 1'b1;
  localparam int   TMO_W    = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_q;
  logic             busy;
  logic             finishing;
`else
  localparam logic IDLE_RDY = 1'b0;
`endif

  state_t             state_q;
  logic [OFF_W-1:0]   off_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic               we_q;
  logic [ADDR_W-1:0]  m_araddr_q;
  logic               m_arvalid_q;
  logic               m_rready_q;
  logic [ADDR_W-1:0]  m_awaddr_q;
  logic               m_awvalid_q;
  logic [DATA_W-1:0]  m_wdata_q;
  logic [NB-1:0]      m_wstrb_q;
  logic               m_wvalid_q;
  logic               m_bready_q;
  logic               aw_done_q;
  logic               w_done_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;
  logic [3:0]         rsp_cause_q;

  logic [OFF_W-1:0]   req_off;
  logic [ADDR_W-1:0]  aligned_addr;
  logic               req_illegal;
  logic               req_misaligned;
  logic [DATA_W-1:0]  wdata_d;
  logic [7:0]         strb_base;
  logic [NB-1:0]      wstrb_d;
  logic [DATA_W-1:0]  rd_shift;
  logic [DATA_W-1:0]  keep_mask;
  logic               ld_sign;
  logic [DATA_W-1:0]  ld_data_d;
  logic               aw_fin;
  logic               w_fin;

  // Request decode: lane offset, alignment/legality and store lane steering
  always_comb begin
    req_off      = bus.req_addr[OFF_W-1:0];
    aligned_addr = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    req_illegal  = (bus.req_size == 2'd3) && (DATA_W == 32);
    case (bus.req_size)
      2'd0:    req_misaligned = 1'b0;
      2'd1:    req_misaligned = bus.req_addr[0];
      2'd2:    req_misaligned = |bus.req_addr[1:0];
      default: req_misaligned = |bus.req_addr[2:0];
    endcase
    case (bus.req_size)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
    wdata_d = bus.req_wdata << {req_off, 3'b000};
    wstrb_d = NB'(strb_base) << req_off;
  end

  // Load result: shift the addressed lane down, keep N bytes, extend
  always_comb begin
    rd_shift  = bus.m_rdata >> {off_q, 3'b000};
    keep_mask = {DATA_W{1'b1}} >> (7'(DATA_W) - (7'd8 << size_q));
    case (size_q)
      2'd0:    ld_sign = rd_shift[7];
      2'd1:    ld_sign = rd_shift[15];
      2'd2:    ld_sign = rd_shift[31];
      default: ld_sign = rd_shift[DATA_W-1];
    endcase
    ld_data_d = (rd_shift & keep_mask) | (~keep_mask & {DATA_W{ld_sign & ~uns_q}});
  end

  // Write-phase completion including a handshake landing this cycle
  always_comb begin
    aw_fin = aw_done_q | (m_awvalid_q & bus.m_awready);
    w_fin  = w_done_q  | (m_wvalid_q  & bus.m_wready);
  end

`ifdef LSU_BUS_TIMEOUT_EN
  // Watchdog qualifiers: states that wait on the bus, and beats that end them
  always_comb begin
    busy      = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                (state_q == S_WR_REQ)  || (state_q == S_WR_RESP);
    finishing = ((state_q == S_RD_DATA) && bus.m_rvalid) ||
                ((state_q == S_WR_RESP) && bus.m_bvalid);
  end
`endif

  // Main FSM with registered bus outputs and response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      m_araddr_q  <= '0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= IDLE_RDY;
      m_awaddr_q  <= '0;
      m_awvalid_q <= 1'b0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      m_wvalid_q  <= 1'b0;
      m_bready_q  <= IDLE_RDY;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_cause_q <= 4'd0;
`ifdef LSU_BUS_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            off_q     <= req_off;
            size_q    <= bus.req_size;
            uns_q     <= bus.req_unsigned;
            we_q      <= bus.req_we;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
            tmo_q     <= '0;
`endif
            if (req_illegal || req_misaligned) begin
              // exception without touching the bus
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_cause_q <= req_illegal ? 4'd2 : (bus.req_we ? 4'd6 : 4'd4);
            end else if (bus.req_we) begin
              state_q     <= S_WR_REQ;
              m_awaddr_q  <= aligned_addr;
              m_awvalid_q <= 1'b1;
              m_wdata_q   <= wdata_d;
              m_wstrb_q   <= wstrb_d;
              m_wvalid_q  <= 1'b1;
              m_rready_q  <= 1'b0;
              m_bready_q  <= 1'b0;
            end else begin
              state_q     <= S_RD_ADDR;
              m_araddr_q  <= aligned_addr;
              m_arvalid_q <= 1'b1;
              m_rready_q  <= 1'b0;
              m_bready_q  <= 1'b0;
            end
          end
        end
        S_RD_ADDR: begin
          if (bus.m_arready) begin
            m_arvalid_q <= 1'b0;
            m_rready_q  <= 1'b1;
            state_q     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (bus.m_rvalid) begin
            m_rready_q  <= 1'b0;
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            if (bus.m_rresp != 2'b00) begin
              rsp_err_q   <= 1'b1;
              rsp_cause_q <= 4'd5;
              rsp_rdata_q <= '0;
            end else begin
              rsp_err_q   <= 1'b0;
              rsp_cause_q <= 4'd0;
              rsp_rdata_q <= ld_data_d;
            end
          end
        end
        S_WR_REQ: begin
          // AW and W retire independently; move on once both have
          if (m_awvalid_q && bus.m_awready) begin
            m_awvalid_q <= 1'b0;
            aw_done_q   <= 1'b1;
          end
          if (m_wvalid_q && bus.m_wready) begin
            m_wvalid_q <= 1'b0;
            m_wstrb_q  <= '0;
            w_done_q   <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            m_bready_q <= 1'b1;
            state_q    <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bus.m_bvalid) begin
            m_bready_q  <= 1'b0;
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= (bus.m_bresp != 2'b00);
            rsp_cause_q <= (bus.m_bresp != 2'b00) ? 4'd7 : 4'd0;
          end
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_cause_q <= 4'd0;
          rsp_rdata_q <= '0;
          m_rready_q  <= IDLE_RDY;
          m_bready_q  <= IDLE_RDY;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef LSU_BUS_TIMEOUT_EN
      // Watchdog: abort a stalled transaction, overriding the case above
      if (busy) begin
        if ((tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) && !finishing) begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_cause_q <= we_q ? 4'd7 : 4'd5;
          rsp_rdata_q <= '0;
          m_arvalid_q <= 1'b0;
          m_awvalid_q <= 1'b0;
          m_wvalid_q  <= 1'b0;
          m_wstrb_q   <= '0;
          m_rready_q  <= 1'b0;
          m_bready_q  <= 1'b0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_cause   = rsp_cause_q;
  assign bus.m_araddr    = m_araddr_q;
  assign bus.m_arvalid   = m_arvalid_q;
  assign bus.m_rready    = m_rready_q;
  assign bus.m_awaddr    = m_awaddr_q;
  assign bus.m_awvalid   = m_awvalid_q;
  assign bus.m_wdata     = m_wdata_q;
  assign bus.m_wstrb     = m_wstrb_q;
  assign bus.m_wvalid    = m_wvalid_q;
  assign bus.m_bready    = m_bready_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_rv_lsu_axil.sv
// Directed bench for rv_lsu_axil: a 32-bit instance carries most vectors,
// a 64-bit instance covers wide-bus lane steering. The watchdog vectors run
// only when LSU_BUS_TIMEOUT_EN is defined.
module tb_rv_lsu_axil;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] st32;
  logic [2:0] st64;
  int n_checks = 0;
  int n_errors = 0;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam logic EXP_IDLE_RDY = 1'b1;
`else
  localparam logic EXP_IDLE_RDY = 1'b0;
`endif

  rv_lsu_axil_if #(.ADDR_W(32), .DATA_W(32)) b32 ();
  rv_lsu_axil_if #(.ADDR_W(32), .DATA_W(64)) b64 ();

  rv_lsu_axil #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut32 (
    .clk(clk), .rst(rst), .bus(b32.master), .dbg_state_o(st32)
  );
  rv_lsu_axil #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(8)) dut64 (
    .clk(clk), .rst(rst), .bus(b64.master), .dbg_state_o(st64)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: load on the 32-bit unit against a zero-wait slave
  task automatic load32(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                        input logic [31:0] rd, input logic [1:0] rr,
                        output logic [31:0] o_araddr, output logic [31:0] o_data,
                        output logic o_err, output logic [3:0] o_cause,
                        output int lat, output int ar_seen);
    o_araddr = '0; o_data = '0; o_err = 1'b0; o_cause = '0; lat = -1; ar_seen = 0;
    b32.req_valid = 1'b1; b32.req_addr = addr; b32.req_we = 1'b0;
    b32.req_size = size; b32.req_unsigned = uns; b32.req_wdata = '0;
    b32.m_arready = 1'b1; b32.m_rdata = rd; b32.m_rresp = rr;
    tick();
    // scramble request fields after acceptance; the unit must have latched them
    b32.req_valid = 1'b0; b32.req_addr = 32'hFFFF_FFFF; b32.req_size = 2'd1;
    b32.req_unsigned = ~uns;
    for (int c = 1; c <= 20; c++) begin
      if (b32.rsp_valid) begin
        o_data = b32.rsp_rdata; o_err = b32.rsp_err; o_cause = b32.rsp_cause; lat = c;
        break;
      end
      if (b32.m_arvalid) begin
        ar_seen++;
        o_araddr = b32.m_araddr;
      end
      b32.m_rvalid = b32.m_rready;
      tick();
    end
    b32.m_rvalid = 1'b0; b32.m_arready = 1'b0;
    tick();
    chk("rsp_one_cycle", b32.rsp_valid, 1'b0);
    chk("ready_after_rsp", b32.req_ready, 1'b1);
  endtask

  // driver: store on the 32-bit unit; W ready at once, AW ready aw_delay later
  task automatic store32(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                         input int aw_delay, input logic [1:0] br,
                         output logic [31:0] o_awaddr, output logic [31:0] o_wdata,
                         output logic [3:0] o_wstrb, output logic o_err, output logic [3:0] o_cause,
                         output int lat, output int aw_beats, output int w_beats);
    o_awaddr = '0; o_wdata = '0; o_wstrb = '0; o_err = 1'b0; o_cause = '0;
    lat = -1; aw_beats = 0; w_beats = 0;
    b32.req_valid = 1'b1; b32.req_addr = addr; b32.req_we = 1'b1;
    b32.req_size = size; b32.req_unsigned = 1'b0; b32.req_wdata = wd;
    b32.m_wready = 1'b1; b32.m_bresp = br;
    tick();
    b32.req_valid = 1'b0; b32.req_wdata = 32'hDEAD_DEAD; b32.req_addr = '0;
    for (int c = 1; c <= 30; c++) begin
      if (b32.rsp_valid) begin
        o_err = b32.rsp_err; o_cause = b32.rsp_cause; lat = c;
        chk("store_rdata_zero", b32.rsp_rdata, 32'h0);
        break;
      end
      b32.m_awready = (c >= 1 + aw_delay);
      if (b32.m_awvalid) o_awaddr = b32.m_awaddr;
      if (b32.m_awvalid && b32.m_awready) aw_beats++;
      if (b32.m_wvalid) begin
        o_wdata = b32.m_wdata; o_wstrb = b32.m_wstrb;
      end
      if (b32.m_wvalid && b32.m_wready) w_beats++;
      b32.m_bvalid = b32.m_bready;
      tick();
    end
    b32.m_bvalid = 1'b0; b32.m_awready = 1'b0; b32.m_wready = 1'b0;
    tick();
    chk("rsp_one_cycle", b32.rsp_valid, 1'b0);
    chk("ready_after_rsp", b32.req_ready, 1'b1);
  endtask

  logic [31:0] a, d, wd;
  logic [3:0]  cause, strb;
  logic        err;
  int          lat, n_ar, n_aw, n_w;

  initial begin
    // idle all driven inputs
    b32.req_valid = 0; b32.req_addr = 0; b32.req_we = 0; b32.req_size = 0;
    b32.req_unsigned = 0; b32.req_wdata = 0; b32.m_arready = 0; b32.m_rdata = 0;
    b32.m_rresp = 0; b32.m_rvalid = 0; b32.m_awready = 0; b32.m_wready = 0;
    b32.m_bresp = 0; b32.m_bvalid = 0;
    b64.req_valid = 0; b64.req_addr = 0; b64.req_we = 0; b64.req_size = 0;
    b64.req_unsigned = 0; b64.req_wdata = 0; b64.m_arready = 0; b64.m_rdata = 0;
    b64.m_rresp = 0; b64.m_rvalid = 0; b64.m_awready = 0; b64.m_wready = 0;
    b64.m_bresp = 0; b64.m_bvalid = 0;

    // reset state
    tick(); tick();
    chk("rst_req_ready", b32.req_ready, 1'b1);
    chk("rst_arvalid", b32.m_arvalid, 1'b0);
    chk("rst_awvalid", b32.m_awvalid, 1'b0);
    chk("rst_wvalid", b32.m_wvalid, 1'b0);
    chk("rst_wstrb", b32.m_wstrb, 4'h0);
    chk("rst_rsp_valid", b32.rsp_valid, 1'b0);
    chk("rst_rsp_err", b32.rsp_err, 1'b0);
    chk("rst_rsp_rdata", b32.rsp_rdata, 32'h0);
    chk("rst_rsp_cause", b32.rsp_cause, 4'h0);
    chk("rst_rready", b32.m_rready, EXP_IDLE_RDY);
    chk("rst_state", st32, 3'd0);
    rst = 1'b0;
    tick();

    // LB 0x103, sign byte 0x80
    load32(32'h103, 2'd0, 1'b0, 32'h80AA_BBCC, 2'b00, a, d, err, cause, lat, n_ar);
    chk("lb_araddr", a, 32'h100);
    chk("lb_rdata", d, 32'hFFFF_FF80);
    chk("lb_err", err, 1'b0);
    chk("lb_latency", lat, 3);
    chk("lb_ar_beats", n_ar, 1);

    // LHU / LH 0x102
    load32(32'h102, 2'd1, 1'b1, 32'h80AA_BBCC, 2'b00, a, d, err, cause, lat, n_ar);
    chk("lhu_rdata", d, 32'h0000_80AA);
    load32(32'h102, 2'd1, 1'b0, 32'h80AA_BBCC, 2'b00, a, d, err, cause, lat, n_ar);
    chk("lh_rdata", d, 32'hFFFF_80AA);
    // LBU 0x101 with positive byte
    load32(32'h101, 2'd0, 1'b1, 32'h80AA_BBCC, 2'b00, a, d, err, cause, lat, n_ar);
    chk("lbu_rdata", d, 32'h0000_00BB);

    // LW aligned
    load32(32'h204, 2'd2, 1'b0, 32'h1234_5678, 2'b00, a, d, err, cause, lat, n_ar);
    chk("lw_araddr", a, 32'h204);
    chk("lw_rdata", d, 32'h1234_5678);

    // LW misaligned 0x6
    load32(32'h6, 2'd2, 1'b0, 32'h1111_1111, 2'b00, a, d, err, cause, lat, n_ar);
    chk("lw_mis_err", err, 1'b1);
    chk("lw_mis_cause", cause, 4'd4);
    chk("lw_mis_latency", lat, 1);
    chk("lw_mis_no_ar", n_ar, 0);
    chk("lw_mis_rdata", d, 32'h0);

    // size 3 on a 32-bit bus
    load32(32'h10, 2'd3, 1'b0, 32'h1111_1111, 2'b00, a, d, err, cause, lat, n_ar);
    chk("ld_illegal_cause", cause, 4'd2);
    chk("ld_illegal_err", err, 1'b1);
    chk("ld_illegal_no_ar", n_ar, 0);

    // load bus error
    load32(32'h300, 2'd2, 1'b0, 32'hABCD_EF01, 2'b10, a, d, err, cause, lat, n_ar);
    chk("ld_buserr_err", err, 1'b1);
    chk("ld_buserr_cause", cause, 4'd5);
    chk("ld_buserr_rdata", d, 32'h0);

    // SH 0x2002, AW accepted 3 cycles after W
    store32(32'h2002, 2'd1, 32'h0000_1234, 3, 2'b00, a, wd, strb, err, cause, lat, n_aw, n_w);
    chk("sh_awaddr", a, 32'h2000);
    chk("sh_wdata", wd, 32'h1234_0000);
    chk("sh_wstrb", strb, 4'b1100);
    chk("sh_err", err, 1'b0);
    chk("sh_latency", lat, 6);
    chk("sh_aw_beats", n_aw, 1);
    chk("sh_w_beats", n_w, 1);

    // SB 0x3001, zero-wait
    store32(32'h3001, 2'd0, 32'h0000_00AB, 0, 2'b00, a, wd, strb, err, cause, lat, n_aw, n_w);
    chk("sb_wdata", wd, 32'h0000_AB00);
    chk("sb_wstrb", strb, 4'b0010);
    chk("sb_latency", lat, 3);

    // SW misaligned
    store32(32'h2, 2'd2, 32'h5555_5555, 0, 2'b00, a, wd, strb, err, cause, lat, n_aw, n_w);
    chk("sw_mis_cause", cause, 4'd6);
    chk("sw_mis_no_aw", n_aw, 0);
    chk("sw_mis_latency", lat, 1);

    // store bus error
    store32(32'h400, 2'd2, 32'hCAFE_F00D, 1, 2'b10, a, wd, strb, err, cause, lat, n_aw, n_w);
    chk("st_buserr_err", err, 1'b1);
    chk("st_buserr_cause", cause, 4'd7);
    chk("st_buserr_wstrb", strb, 4'hF);

    // reset while waiting in RD_DATA
    b32.req_valid = 1; b32.req_addr = 32'h40; b32.req_we = 0; b32.req_size = 2'd2;
    b32.m_arready = 1;
    tick();
    b32.req_valid = 0;
    tick();
    chk("rdwait_rready", b32.m_rready, 1'b1);
    b32.m_arready = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ready", b32.req_ready, 1'b1);
    chk("rst_mid_rsp", b32.rsp_valid, 1'b0);
    chk("rst_mid_rready", b32.m_rready, EXP_IDLE_RDY);
    tick();
    chk("rst_mid_no_rsp", b32.rsp_valid, 1'b0);

    // 64-bit bus: LWU 0x0C
    b64.req_valid = 1; b64.req_addr = 32'h0C; b64.req_we = 0; b64.req_size = 2'd2;
    b64.req_unsigned = 1;
    tick();
    b64.req_valid = 0;
    chk("lwu64_arvalid", b64.m_arvalid, 1'b1);
    chk("lwu64_araddr", b64.m_araddr, 32'h08);
    b64.m_arready = 1;
    tick();
    b64.m_arready = 0;
    chk("lwu64_ar_drop", b64.m_arvalid, 1'b0);
    b64.m_rvalid = 1; b64.m_rdata = 64'hDEAD_BEEF_0000_0000;
    tick();
    b64.m_rvalid = 0;
    chk("lwu64_rsp_valid", b64.rsp_valid, 1'b1);
    chk("lwu64_rdata", b64.rsp_rdata, 64'h0000_0000_DEAD_BEEF);
    tick();

    // 64-bit bus: SW 0x0C, lanes 4..7
    b64.req_valid = 1; b64.req_addr = 32'h0C; b64.req_we = 1; b64.req_size = 2'd2;
    b64.req_wdata = 64'h0000_0000_1122_3344;
    tick();
    b64.req_valid = 0;
    chk("sw64_awaddr", b64.m_awaddr, 32'h08);
    chk("sw64_wdata", b64.m_wdata, 64'h1122_3344_0000_0000);
    chk("sw64_wstrb", b64.m_wstrb, 8'hF0);
    b64.m_awready = 1; b64.m_wready = 1;
    tick();
    b64.m_awready = 0; b64.m_wready = 0;
    chk("sw64_bready", b64.m_bready, 1'b1);
    b64.m_bvalid = 1;
    tick();
    b64.m_bvalid = 0;
    chk("sw64_rsp_valid", b64.rsp_valid, 1'b1);
    chk("sw64_rsp_err", b64.rsp_err, 1'b0);
    tick();

`ifdef LSU_BUS_TIMEOUT_EN
    // slave never answers a load
    b32.req_valid = 1; b32.req_addr = 32'h80; b32.req_we = 0; b32.req_size = 2'd2;
    tick();
    b32.req_valid = 0;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      if (b32.rsp_valid) begin
        lat = c;
        chk("tmo_err", b32.rsp_err, 1'b1);
        chk("tmo_cause", b32.rsp_cause, 4'd5);
        chk("tmo_arvalid", b32.m_arvalid, 1'b0);
        chk("tmo_awvalid", b32.m_awvalid, 1'b0);
        chk("tmo_wvalid", b32.m_wvalid, 1'b0);
        break;
      end
      tick();
    end
    chk("tmo_latency_window", (lat >= 8 && lat <= 10), 1'b1);
    tick();
    // late read beat arriving in IDLE
    chk("tmo_idle_rready", b32.m_rready, 1'b1);
    b32.m_rvalid = 1; b32.m_rdata = 32'h7777_7777;
    tick();
    b32.m_rvalid = 0;
    chk("late_beat_no_rsp", b32.rsp_valid, 1'b0);
    chk("late_beat_ready", b32.req_ready, 1'b1);
    tick();
    chk("late_beat_no_rsp2", b32.rsp_valid, 1'b0);
`endif

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_lsu_axil.md
Name: rv_lsu_axil

Overview:
- Parametrised load/store unit for the RV core family. Replaces the core's inline byte-lane and AXI4-Lite data-side logic with a standalone sequential master.
- Accepts one load/store request at a time from the execute stage. Performs alignment checking, lane steering, strobe generation and sign/zero extension for 32- or 64-bit buses.
- Runs the AXI4-Lite handshake and returns a single-cycle response carrying data or a RISC-V exception cause.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, bus/register data width; legal values 32 or 64.
- TIMEOUT_CYCLES, 256, bus watchdog limit. Used only with the optional feature; must be ≥2.

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_addr  in  ADDR_W  byte address
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte 1=half 2=word 3=dword
- req_unsigned  in  1  zero-extend load result
- req_wdata  in  DATA_W  store value, LSB-justified
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- rsp_err  out  1  exception on this request
- rsp_cause  out  4  mcause code when rsp_err=1, else 0
- m_araddr/m_arvalid/m_arready, m_rdata/m_rresp/m_rvalid/m_rready: AXI4-Lite read channels (ADDR_W, DATA_W, 2-bit resp)
- m_awaddr/m_awvalid/m_awready, m_wdata/m_wstrb/m_wvalid/m_wready, m_bresp/m_bvalid/m_bready: AXI4-Lite write channels (wstrb is DATA_W/8)

Behaviour:
- One clock; reset is synchronous and active-high.
- On rst: state=IDLE; all valids, rsp_err and wstrb are 0; rsp_rdata=0 and rsp_cause=0. Any in-flight transaction is abandoned silently, with no response.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP. req_ready=1 only in IDLE.
- Accept on req_valid&&req_ready. All request fields are latched; later changes to req_* are ignored.
- Let OFF = req_addr[log2(DATA_W/8)-1:0] and N = 1<<req_size bytes.
- Illegal or misaligned request goes IDLE→RESP with no bus activity:
  - size=3 with DATA_W=32 → cause 2.
  - addr mod N ≠ 0 → cause 4 (load) or 6 (store).
- Load: IDLE→RD_ADDR.
  - m_araddr = addr with low OFF bits cleared; m_arvalid held until m_arready, then RD_DATA.
  - m_rready=1 in RD_DATA; on m_rvalid → RESP.
  - Result = m_rdata >> (8*OFF), truncated to N bytes, then sign- or zero-extended to DATA_W.
- Store: IDLE→WR_REQ.
  - m_awvalid and m_wvalid assert together; each drops independently on its own ready. Track aw_done and w_done; both done → WR_RESP.
  - m_wdata = req_wdata << (8*OFF); m_wstrb = ((1<<N)-1) << OFF.
  - m_bready=1 in WR_RESP; on m_bvalid → RESP.
- Bus error: m_rresp or m_bresp ≠ 0 gives rsp_err=1, cause 5 (load) or 7 (store), rsp_rdata=0.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The next request can be accepted the cycle after RESP.
- Minimum latency with zero-wait slave, accept at cycle 0:
  - load: arvalid cycles 1; rvalid cycle 2; rsp_valid cycle 3.
  - misaligned: rsp_valid cycle 1.
- All AXI outputs are registered. m_arvalid, m_awvalid and m_wvalid never deassert before their ready.

Optional Feature:
- LSU_BUS_TIMEOUT_EN defined:
  - A counter runs in RD_ADDR, RD_DATA, WR_REQ and WR_RESP and clears on entry to each request.
  - At TIMEOUT_CYCLES it forces RESP with err, cause 5 (load) or 7 (store), and drops all valids.
  - m_rready and m_bready are also held 1 in IDLE, so stray late beats are consumed and discarded.
- Undefined: no counter; the unit waits on the bus indefinitely; rready/bready are asserted only in their wait states.

Test Plan:
- LB, DATA_W=32, addr 0x103, rdata 0x80AA_BBCC, zero-wait slave → araddr 0x100, rsp_rdata 0xFFFF_FF80, err 0, rsp_valid 3 cycles after accept.
- SH, addr 0x2002, wdata 0x1234, awready 3 cycles after wready → wdata 0x1234_0000, wstrb 4'b1100, single response after bvalid.
- LW addr 0x6 → rsp_err=1, cause 4, rsp_valid on cycle 1; arvalid never asserted.
- DATA_W=64, LWU addr 0x0C, rdata 0xDEAD_BEEF_0000_0000 → araddr 0x08, rsp_rdata 0x0000_0000_DEAD_BEEF. With DATA_W=32, size=3 → cause 2.
- Store with bresp=2'b10 → err 1, cause 7. rst asserted while in RD_DATA → next cycle IDLE, req_ready=1, no rsp_valid.
- LSU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds → err 1, cause 5, all valids low. Then a late rvalid in IDLE is consumed without producing rsp_valid.
